pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//  Central pipeline hazard controller for the NSTAGE in-order core, the parametrised successor of the fixed 6-bit stall ctrl.
//  Merges per-stage stall requests and an external bus-freeze into stall/bubble vectors, and sequences redirect flushes.
//  Keeps a saturating stall-cycle counter and a stall watchdog. Sits beside the pipeline; its outputs feed every stage register.
// PARAMETERS
//  NSTAGE  6     pipeline stages; index 0 = IF ... NSTAGE-1 = WB
//  PC_W    32    redirect PC width
//  CNT_W   16    stall-cycle counter width
//  WDOG    1024  consecutive-stall limit that raises wdog_err; 0 disables the watchdog
// PORTS
//  clk           in   1       clock
//  rst_n         in   1       reset, synchronous, active-low
//  stallreq      in   NSTAGE  stallreq[i]=1: stage i cannot advance this cycle
//  stallreq_bus  in   1       external memory/bus not ready; freezes the whole pipe
//  flush_req     in   1       redirect request (exception/mispredict), sampled at posedge
//  flush_pc      in   PC_W    redirect target, sampled with flush_req
//  stall         out  NSTAGE  stall[j]=1: stage-j register holds its value
//  bubble        out  NSTAGE  bubble[j]=1: stage-j register loads a NOP
//  flush         out  NSTAGE  flush[j]=1: stage-j register is cleared to NOP
//  new_pc_valid  out  1       one-cycle pulse; the fetch unit loads new_pc
//  new_pc        out  PC_W    redirect PC; valid only while new_pc_valid=1
//  stall_cycles  out  CNT_W   count of cycles with stall[0]=1; saturates at all-ones
//  wdog_err      out  1       sticky; asserts when a consecutive stall reaches WDOG cycles
// BEHAVIOUR
//  Reset: while rst_n=0 at posedge, all registers clear. The combinational outputs stall, bubble, flush and new_pc_valid are forced to 0 while rst_n=0.
//  Stall mask (combinational):
//   - k = highest i with stallreq[i]=1. Then stall[j]=1 for j<=k, and bubble[k+1]=1 if k+1<NSTAGE; all other bits are 0.
//   - The highest requester wins because its mask is a superset of the lower ones.
//   - stallreq_bus=1 gives stall = all ones and bubble = 0, regardless of stallreq.
//  Flush sequencing (registers pend, pend_pc):
//   - fire = pend & ~stallreq_bus.
//   - While fire=1: flush = all ones, new_pc_valid=1, new_pc=pend_pc. The local stall mask and bubble are forced to 0 in that cycle.
//   - At posedge: if flush_req, then pend<=1 and pend_pc<=flush_pc; else if fire, pend<=0.
//   - Flush latency is 1 cycle from flush_req when the bus is idle.
//   - While the bus is stalled the flush is held and fires on the first cycle with stallreq_bus=0.
//   - A new flush_req while pend=1 and not firing overwrites pend_pc (newest wins).
//   - A flush_req in the same cycle as fire leaves pend=1 with the new PC, so the next cycle fires a second flush.
//  Stall counter: +1 at each posedge where stall[0]=1, saturating at 2^CNT_W-1. Cleared only by reset.
//  Watchdog (WDOG>0):
//   - run counter (width clog2(WDOG+1)) counts +1 each cycle with stall[0]=1 and clears to 0 when stall[0]=0.
//   - When run reaches WDOG, wdog_err<=1; it stays set until reset and run saturates.
//   - With WDOG=0 the run counter and wdog_err are tied off to 0.
//  A mid-operation reset drops any pending flush without issuing new_pc_valid.
// STRUCTURE
//  pipe_ctrl_pkg: NSTAGE default, stage index constants STG_IF..STG_WB, and the PC_W default, shared with the stage registers.
//  Sub-module sat_counter #(W): enable/clear saturating up-counter, used for both stall_cycles and the watchdog run counter.
//  The stall mask is a priority-encode (highest set bit) followed by a thermometer expansion.
// TESTING
//  1 NSTAGE=6, stallreq=6'b001000 -> stall=6'b001111, bubble=6'b010000.
//  2 stallreq=6'b011000 -> stall=6'b011111, bubble=6'b100000.
//    Add stallreq_bus=1 -> stall=6'b111111, bubble=0.
//  3 Bus idle, flush_req=1 with flush_pc=32'h8000_0100 -> next cycle flush=6'h3F, new_pc_valid=1, new_pc=32'h8000_0100; pulse lasts exactly 1 cycle.
//  4 flush_req (pc 0x100) under stallreq_bus=1 for 3 cycles, second flush_req (pc 0x200) during the stall
//    -> single fire on the first bus-free cycle with new_pc=0x200.
//    Back-to-back flush_req in the firing cycle -> two consecutive pulses.
//  5 WDOG=8, stallreq[2] held 8 cycles -> wdog_err=1 and stays 1 after release.
//    stall_cycles=8. With CNT_W=3, a further stall holds the counter at 7.
//  6 Assert rst_n=0 while pend=1 and the bus is stalled -> all outputs 0 after the reset edge, and no new_pc_valid after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control constants.
// Stage indices and default widths used by the stage registers.
package pipe_ctrl_pkg;

  localparam int NSTAGE_DEF = 6;
  localparam int PC_W_DEF   = 32;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_IS  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
// Holds at all-ones once reached; clear has priority over enable.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  // count up on enable, stop at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central hazard controller: stall/bubble masks, redirect flush,
// stall-cycle counter and consecutive-stall watchdog.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = NSTAGE_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int CNT_W  = 16,
  parameter int WDOG   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              stallreq_bus,
  input  logic              flush_req,
  input  logic [PC_W-1:0]   flush_pc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] bubble,
  output logic [NSTAGE-1:0] flush,
  output logic              new_pc_valid,
  output logic [PC_W-1:0]   new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              wdog_err
);

  localparam int IDX_W = $clog2(NSTAGE + 1);
  localparam int RUN_W = (WDOG > 0) ? $clog2(WDOG + 1) : 1;

  logic              hit;
  logic [IDX_W-1:0]  top_idx;
  logic [NSTAGE-1:0] mask;
  logic [NSTAGE-1:0] bub;
  logic              pend;
  logic [PC_W-1:0]   pend_pc;
  logic              fire;
  logic              stall_if;

  assign fire     = pend & ~stallreq_bus;
  assign stall_if = stall[STG_IF];

  // priority encode: highest requesting stage
  always_comb begin
    hit     = 1'b0;
    top_idx = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stallreq[i]) begin
        hit     = 1'b1;
        top_idx = IDX_W'(i);
      end
    end
  end

  // thermometer below the winner, bubble just above it
  always_comb begin
    mask = '0;
    bub  = '0;
    for (int j = 0; j < NSTAGE; j++) begin
      if (hit && (j <= int'(top_idx))) begin
        mask[j] = 1'b1;
      end
      if (hit && (j == int'(top_idx) + 1)) begin
        bub[j] = 1'b1;
      end
    end
  end

  // merge flush, bus freeze and local mask; all quiet in reset
  always_comb begin
    stall        = '0;
    bubble       = '0;
    flush        = '0;
    new_pc_valid = 1'b0;
    if (rst_n) begin
      if (fire) begin
        flush        = '1;
        new_pc_valid = 1'b1;
      end else if (stallreq_bus) begin
        stall = '1;
      end else begin
        stall  = mask;
        bubble = bub;
      end
    end
  end

  assign new_pc = new_pc_valid ? pend_pc : '0;

  // pending redirect: newest request wins, cleared when it fires
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      pend_pc <= '0;
    end else if (flush_req) begin
      pend    <= 1'b1;
      pend_pc <= flush_pc;
    end else if (fire) begin
      pend    <= 1'b0;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_if),
    .clr   (1'b0),
    .q     (stall_cycles)
  );

  generate
    if (WDOG > 0) begin : g_wdog
      logic [RUN_W-1:0] run;
      logic             err_q;

      sat_counter #(
        .W (RUN_W)
      ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (stall_if && (run != RUN_W'(WDOG))),
        .clr   (~stall_if),
        .q     (run)
      );

      // sticky error on the edge that makes the run reach the limit
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          err_q <= 1'b0;
        end else if (stall_if && (run >= RUN_W'(WDOG - 1))) begin
          err_q <= 1'b1;
        end
      end

      assign wdog_err = err_q;
    end else begin : g_no_wdog
      assign wdog_err = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipe_stall_ctrl;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  stallreq;
  logic          stallreq_bus;
  logic          flush_req;
  logic [31:0]   flush_pc;

  logic [N-1:0]  stall, bubble, flush;
  logic          new_pc_valid;
  logic [31:0]   new_pc;
  logic [15:0]   stall_cycles;
  logic          wdog_err;

  logic [N-1:0]  stall_s, bubble_s, flush_s;
  logic          new_pc_valid_s;
  logic [31:0]   new_pc_s;
  logic [2:0]    stall_cycles_s;
  logic          wdog_err_s;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_cnt, m_cnt_s, m_run;
  bit          m_err;
  logic [N-1:0] e_stall, e_bubble, e_flush;
  logic         e_v;
  logic [31:0]  e_pc;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .NSTAGE (N), .PC_W (32), .CNT_W (16), .WDOG (8)
  ) dut (
    .clk (clk), .rst_n (rst_n), .stallreq (stallreq),
    .stallreq_bus (stallreq_bus), .flush_req (flush_req),
    .flush_pc (flush_pc), .stall (stall), .bubble (bubble),
    .flush (flush), .new_pc_valid (new_pc_valid),
    .new_pc (new_pc), .stall_cycles (stall_cycles),
    .wdog_err (wdog_err)
  );

  pipe_stall_ctrl #(
    .NSTAGE (N), .PC_W (32), .CNT_W (3), .WDOG (0)
  ) dut_s (
    .clk (clk), .rst_n (rst_n), .stallreq (stallreq),
    .stallreq_bus (stallreq_bus), .flush_req (flush_req),
    .flush_pc (flush_pc), .stall (stall_s), .bubble (bubble_s),
    .flush (flush_s), .new_pc_valid (new_pc_valid_s),
    .new_pc (new_pc_s), .stall_cycles (stall_cycles_s),
    .wdog_err (wdog_err_s)
  );

  // expected combinational outputs from the rules
  task automatic compute_expect();
    int k;
    e_stall = '0; e_bubble = '0; e_flush = '0;
    e_v = 1'b0; e_pc = m_pc;
    if (rst_n !== 1'b1) return;
    if (m_pend && !stallreq_bus) begin
      e_flush = '1;
      e_v = 1'b1;
    end else if (stallreq_bus) begin
      e_stall = '1;
    end else begin
      k = -1;
      for (int i = 0; i < N; i++) if (stallreq[i]) k = i;
      if (k >= 0) begin
        e_stall = N'((1 << (k + 1)) - 1);
        if (k + 1 < N) e_bubble = N'(1 << (k + 1));
      end
    end
  endtask

  // advance model state across one rising edge
  task automatic model_edge();
    if (rst_n !== 1'b1) begin
      m_pend = 0; m_pc = '0; m_cnt = 0;
      m_cnt_s = 0; m_run = 0; m_err = 0;
    end else begin
      if (e_stall[0]) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 7) m_cnt_s++;
        if (m_run < 8) m_run++;
        if (m_run >= 8) m_err = 1;
      end else begin
        m_run = 0;
      end
      if (flush_req) begin
        m_pend = 1; m_pc = flush_pc;
      end else if (e_v) begin
        m_pend = 0;
      end
    end
  endtask

  task automatic apply(input logic [N-1:0] sr, input logic b,
                       input logic f, input logic [31:0] p,
                       input logic r);
    @(negedge clk);
    stallreq = sr; stallreq_bus = b;
    flush_req = f; flush_pc = p; rst_n = r;
    #1;
    compute_expect();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
  endtask

  task automatic test_reset();
    apply(6'h3F, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    nvec++;
    if (stall !== 6'h00 || flush !== 6'h00 || new_pc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_comb stall=%b flush=%b v=%b want 0", stall, flush, new_pc_valid);
    end
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (stall_cycles !== 16'd0 || wdog_err !== 1'b0 || new_pc_valid !== 1'b0
        || stall !== 6'h00 || bubble !== 6'h00) begin
      nerr++;
      $display("FAIL reset_state cnt=%0d err=%b v=%b stall=%b bubble=%b want 0",
               stall_cycles, wdog_err, new_pc_valid, stall, bubble);
    end
    tick();
  endtask

  task automatic test_mask();
    apply(6'b001000, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (stall !== 6'b001111 || bubble !== 6'b010000) begin
      nerr++;
      $display("FAIL mask_k3 stall=%b bubble=%b want 001111/010000", stall, bubble);
    end
    tick();
    apply(6'b011000, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (stall !== 6'b011111 || bubble !== 6'b100000) begin
      nerr++;
      $display("FAIL mask_k4 stall=%b bubble=%b want 011111/100000", stall, bubble);
    end
    tick();
    apply(6'b011000, 1'b1, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (stall !== 6'b111111 || bubble !== 6'b000000) begin
      nerr++;
      $display("FAIL mask_bus stall=%b bubble=%b want 111111/000000", stall, bubble);
    end
    tick();
    apply(6'b100001, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (stall !== 6'b111111 || bubble !== 6'b000000) begin
      nerr++;
      $display("FAIL mask_top stall=%b bubble=%b want 111111/000000", stall, bubble);
    end
    tick();
    apply(6'b000001, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (stall !== 6'b000001 || bubble !== 6'b000010) begin
      nerr++;
      $display("FAIL mask_k0 stall=%b bubble=%b want 000001/000010", stall, bubble);
    end
    tick();
  endtask

  task automatic test_flush();
    apply(6'h00, 1'b0, 1'b1, 32'h8000_0100, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_early v=%b want 0", new_pc_valid);
    end
    tick();
    apply(6'b000100, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (flush !== 6'h3F || new_pc_valid !== 1'b1 || new_pc !== 32'h8000_0100
        || stall !== 6'h00 || bubble !== 6'h00) begin
      nerr++;
      $display("FAIL flush_fire flush=%h v=%b pc=%h stall=%b want 3f/1/80000100/0",
               flush, new_pc_valid, new_pc, stall);
    end
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b0 || flush !== 6'h00) begin
      nerr++;
      $display("FAIL flush_pulse v=%b flush=%h want 0/00", new_pc_valid, flush);
    end
    tick();
  endtask

  task automatic test_flush_bus();
    apply(6'h00, 1'b1, 1'b1, 32'h100, 1'b1);
    tick();
    apply(6'h00, 1'b1, 1'b1, 32'h200, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b0 || stall !== 6'h3F) begin
      nerr++;
      $display("FAIL flush_held1 v=%b stall=%b want 0/111111", new_pc_valid, stall);
    end
    tick();
    apply(6'h00, 1'b1, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_held2 v=%b want 0", new_pc_valid);
    end
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b1 || new_pc !== 32'h200) begin
      nerr++;
      $display("FAIL flush_newest v=%b pc=%h want 1/00000200", new_pc_valid, new_pc);
    end
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL flush_single v=%b want 0", new_pc_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    apply(6'h00, 1'b0, 1'b1, 32'h300, 1'b1);
    tick();
    apply(6'h00, 1'b0, 1'b1, 32'h400, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b1 || new_pc !== 32'h300) begin
      nerr++;
      $display("FAIL b2b_first v=%b pc=%h want 1/00000300", new_pc_valid, new_pc);
    end
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b1 || new_pc !== 32'h400) begin
      nerr++;
      $display("FAIL b2b_second v=%b pc=%h want 1/00000400", new_pc_valid, new_pc);
    end
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (new_pc_valid !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_end v=%b want 0", new_pc_valid);
    end
    tick();
  endtask

  task automatic test_wdog();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int c = 0; c < 8; c++) begin
      apply(6'b000100, 1'b0, 1'b0, 32'h0, 1'b1);
      if (c == 7) begin
        nvec++;
        if (wdog_err !== 1'b0) begin
          nerr++;
          $display("FAIL wdog_early err=%b want 0", wdog_err);
        end
      end
      tick();
    end
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (wdog_err !== 1'b1 || stall_cycles !== 16'd8 || stall_cycles_s !== 3'd7) begin
      nerr++;
      $display("FAIL wdog_trip err=%b cnt=%0d cnt_s=%0d want 1/8/7",
               wdog_err, stall_cycles, stall_cycles_s);
    end
    tick();
    apply(6'b000001, 1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    nvec++;
    if (wdog_err !== 1'b1 || stall_cycles !== 16'd9 || stall_cycles_s !== 3'd7
        || wdog_err_s !== 1'b0) begin
      nerr++;
      $display("FAIL wdog_sticky err=%b cnt=%0d cnt_s=%0d err_s=%b want 1/9/7/0",
               wdog_err, stall_cycles, stall_cycles_s, wdog_err_s);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    apply(6'h00, 1'b1, 1'b1, 32'h500, 1'b1);
    tick();
    apply(6'h00, 1'b1, 1'b0, 32'h0, 1'b0);
    nvec++;
    if (stall !== 6'h00 || new_pc_valid !== 1'b0 || flush !== 6'h00) begin
      nerr++;
      $display("FAIL rstmid_comb stall=%b v=%b flush=%h want 0", stall, new_pc_valid, flush);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b1);
      nvec++;
      if (new_pc_valid !== 1'b0 || flush !== 6'h00 || stall_cycles !== 16'd0
          || wdog_err !== 1'b0 || stall_cycles_s !== 3'd0) begin
        nerr++;
        $display("FAIL rstmid_after v=%b flush=%h cnt=%0d err=%b want 0",
                 new_pc_valid, flush, stall_cycles, wdog_err);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] sr;
    logic b, f, r;
    apply(6'h00, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    for (int c = 0; c < 400; c++) begin
      sr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      b  = ($urandom_range(0, 3) == 0);
      f  = ($urandom_range(0, 5) == 0);
      r  = ($urandom_range(0, 49) != 0);
      apply(sr, b, f, $urandom, r);
      nvec++;
      if (stall !== e_stall || bubble !== e_bubble || flush !== e_flush
          || new_pc_valid !== e_v || (e_v && new_pc !== e_pc)
          || stall_cycles !== 16'(m_cnt) || wdog_err !== m_err
          || stall_cycles_s !== 3'(m_cnt_s) || wdog_err_s !== 1'b0) begin
        nerr++;
        $display("FAIL rand_%0d st=%b/%b bu=%b/%b fl=%h/%h v=%b/%b pc=%h/%h cnt=%0d/%0d err=%b/%b cs=%0d/%0d",
                 c, stall, e_stall, bubble, e_bubble, flush, e_flush,
                 new_pc_valid, e_v, new_pc, e_pc, stall_cycles, m_cnt,
                 wdog_err, m_err, stall_cycles_s, m_cnt_s);
      end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; stallreq = '0; stallreq_bus = 1'b0;
    flush_req = 1'b0; flush_pc = '0;
    m_pend = 0; m_pc = '0; m_cnt = 0; m_cnt_s = 0; m_run = 0; m_err = 0;
    test_reset();
    test_mask();
    test_flush();
    test_flush_bus();
    test_back_to_back();
    test_wdog();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
